dkong_sprite_dma: RTL and testbench

- Bus-mastering block-copy engine that transfers sprite attribute data from CPU work RAM to the video object RAM once per frame.
- Sits upstream of the video core's object RAM port (7000h-73FFh) on the system bus.
- Armed by the bitmapped IO dma_rdy latch, triggered by the vblank rising edge.
- Takes the bus from the CPU through a Z80-style BUSRQ/BUSAK handshake.

---
 rtl/dkong_sprite_dma.sv | 297 +++++++++++++++++++++++++++++
 tb/tb_dkong_sprite_dma.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dkong_sprite_dma.sv
// dkong_sprite_dma
// Once-per-frame block copier that moves sprite attribute bytes from CPU work
// RAM into the video object RAM. It is armed by the dma_rdy level, fires on
// the rising edge of vblk, and borrows the bus from the CPU through a Z80-style
// BUSRQ/BUSAK handshake.
//
// Each byte takes five clocks with no waits:
//   RD, RD, GAP, WR, GAP
// The two read cycles cover a slave that returns data one clock late.
//
// Optional build macro: SPRITE_DMA_ABORT_EN
//   Adds the i_abort input and the sticky o_aborted output.
//
// Ports
//   i_masterclk   system clock, rising edge
//   i_rst         synchronous active-high reset
//   i_dma_rdy     arm level
//   i_vblk        vertical blank level
//   o_busrq_n     bus request to the CPU, active low
//   i_busak_n     bus acknowledge from the CPU, active low
//   o_addr        master address while the bus is owned
//   o_dmaster     write data
//   i_dslave      read data from the selected slave
//   o_mreq_n      memory request strobe, active low
//   o_rdn         read strobe, active low
//   o_wrn         write strobe, active low
//   i_mwait       slave ready (0 = wait)
//   o_bus_own     engine owns the bus (select for the master mux)
//   o_busy        transfer accepted and not yet back in IDLE
//   o_done        one-cycle completion pulse
//   o_overrun     sticky flag: trigger seen while busy
//
// State | meaning
// IDLE  | waiting for a trigger; all bus outputs at rest
// REQ   | busrq_n held low, waiting for busak_n
// RD    | read strobe on the source address, at least two cycles
// GAP   | strobes released between a read and a write
// WR    | write strobe on the destination address
// REL   | bus released, waiting for the CPU to drop busak_n
module dkong_sprite_dma #(
  parameter logic [15:0] SRC_BASE = 16'h6900,
  parameter logic [15:0] DST_BASE = 16'h7000,
  parameter int unsigned XFER_LEN = 384
) (
  input  logic        i_masterclk,
  input  logic        i_rst,
  input  logic        i_dma_rdy,
  input  logic        i_vblk,
  output logic        o_busrq_n,
  input  logic        i_busak_n,
  output logic [15:0] o_addr,
  output logic [7:0]  o_dmaster,
  input  logic [7:0]  i_dslave,
  output logic        o_mreq_n,
  output logic        o_rdn,
  output logic        o_wrn,
  input  logic        i_mwait,
  output logic        o_bus_own,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_overrun
`ifdef SPRITE_DMA_ABORT_EN
  ,
  input  logic        i_abort,
  output logic        o_aborted
`endif
);

  localparam logic [12:0] LEN = 13'(XFER_LEN);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_RD   = 3'd2,
    S_GAP  = 3'd3,
    S_WR   = 3'd4,
    S_REL  = 3'd5
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic        r_vblk_d;
  logic [15:0] r_src;
  logic [15:0] r_dst;
  logic [12:0] r_cnt;
  logic [7:0]  r_data;
  logic        r_rd_second;   // RD has already spent one cycle on this byte
  logic        r_gap_to_wr;   // GAP sits between a read and its write
  logic        r_stop;        // leave for REL once the current byte is written
  logic        r_quiet;       // suppress the done pulse (aborted transfer)
  logic        r_done;
  logic        r_overrun;

  logic        w_trig;
  logic        w_abort;
  logic        w_in_xfer;
  logic        w_stop_now;
  logic        w_stop_req;
  logic        w_rd_done;
  logic        w_last;

`ifdef SPRITE_DMA_ABORT_EN
  logic        r_aborted;
  assign w_abort   = i_abort;
  assign o_aborted = r_aborted;
`else
  assign w_abort   = 1'b0;
`endif

  assign w_trig     = i_vblk & ~r_vblk_d & i_dma_rdy;
  assign w_in_xfer  = (r_state == S_RD) || (r_state == S_GAP) || (r_state == S_WR);
  // A CPU that drops its acknowledge mid-transfer is treated like an abort:
  // the byte in flight is finished, then the bus is handed back.
  assign w_stop_now = i_busak_n | w_abort;
  assign w_stop_req = r_stop | w_stop_now;
  assign w_rd_done  = (r_state == S_RD) && r_rd_second && i_mwait;
  assign w_last     = (r_cnt == 13'd1);

  // State register and datapath
  always_ff @(posedge i_masterclk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_vblk_d    <= 1'b0;
      r_src       <= 16'h0000;
      r_dst       <= 16'h0000;
      r_cnt       <= 13'd0;
      r_data      <= 8'h00;
      r_rd_second <= 1'b0;
      r_gap_to_wr <= 1'b0;
      r_stop      <= 1'b0;
      r_quiet     <= 1'b0;
      r_done      <= 1'b0;
      r_overrun   <= 1'b0;
`ifdef SPRITE_DMA_ABORT_EN
      r_aborted   <= 1'b0;
`endif
    end else begin
      r_state  <= w_next;
      r_vblk_d <= i_vblk;
      r_done   <= 1'b0;

      if (w_trig && (r_state != S_IDLE)) begin
        r_overrun <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (w_trig) begin
            if (LEN == 13'd0) begin
              r_done <= 1'b1;
            end else begin
              r_src   <= SRC_BASE;
              r_dst   <= DST_BASE;
              r_cnt   <= LEN;
              r_stop  <= 1'b0;
              r_quiet <= 1'b0;
            end
          end
        end
        S_REQ: begin
          r_rd_second <= 1'b0;
          r_gap_to_wr <= 1'b0;
`ifdef SPRITE_DMA_ABORT_EN
          if (w_abort) begin
            r_aborted <= 1'b1;
          end
`endif
        end
        S_RD: begin
          r_rd_second <= 1'b1;
          if (w_rd_done) begin
            r_data      <= i_dslave;
            r_gap_to_wr <= 1'b1;
          end
        end
        S_GAP: begin
          r_rd_second <= 1'b0;
        end
        S_WR: begin
          if (i_mwait) begin
            r_src       <= r_src + 16'h0001;
            r_dst       <= r_dst + 16'h0001;
            r_cnt       <= r_cnt - 13'd1;
            r_gap_to_wr <= 1'b0;
          end
        end
        S_REL: begin
          if (i_busak_n && !r_quiet) begin
            r_done <= 1'b1;
          end
        end
        default: ;
      endcase

      if (w_in_xfer && w_stop_now) begin
        r_stop <= 1'b1;
      end
      if (w_in_xfer && w_abort) begin
        r_quiet <= 1'b1;
`ifdef SPRITE_DMA_ABORT_EN
        r_aborted <= 1'b1;
`endif
      end
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_trig && (LEN != 13'd0)) begin
          w_next = S_REQ;
        end
      end
      S_REQ: begin
        if (w_abort) begin
          w_next = S_IDLE;
        end else if (!i_busak_n) begin
          w_next = S_RD;
        end
      end
      S_RD: begin
        if (w_rd_done) begin
          w_next = S_GAP;
        end
      end
      S_GAP: begin
        if (r_gap_to_wr) begin
          w_next = S_WR;
        end else if (w_stop_req) begin
          w_next = S_REL;
        end else begin
          w_next = S_RD;
        end
      end
      S_WR: begin
        if (i_mwait) begin
          if (w_last || w_stop_req) begin
            w_next = S_REL;
          end else begin
            w_next = S_GAP;
          end
        end
      end
      S_REL: begin
        if (i_busak_n) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Output decode; bus outputs sit at their rest values whenever the bus
  // is not owned, so reset or release returns them on the same edge.
  always_comb begin
    o_busrq_n = 1'b1;
    o_addr    = 16'h0000;
    o_dmaster = 8'h00;
    o_mreq_n  = 1'b1;
    o_rdn     = 1'b1;
    o_wrn     = 1'b1;
    o_bus_own = 1'b0;
    case (r_state)
      S_REQ: begin
        o_busrq_n = 1'b0;
      end
      S_RD: begin
        o_busrq_n = 1'b0;
        o_bus_own = 1'b1;
        o_addr    = r_src;
        o_mreq_n  = 1'b0;
        o_rdn     = 1'b0;
      end
      S_GAP: begin
        o_busrq_n = 1'b0;
        o_bus_own = 1'b1;
      end
      S_WR: begin
        o_busrq_n = 1'b0;
        o_bus_own = 1'b1;
        o_addr    = r_dst;
        o_dmaster = r_data;
        o_mreq_n  = 1'b0;
        o_wrn     = 1'b0;
      end
      default: ;
    endcase
  end

  assign o_busy    = (r_state != S_IDLE);
  assign o_done    = r_done;
  assign o_overrun = r_overrun;

endmodule

// File: tb/tb_dkong_sprite_dma.sv
module tb_dkong_sprite_dma;
  localparam int N = 384;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst = 1'b1;

  // main instance (default parameters)
  logic        dma_rdy = 1'b0, vblk = 1'b0, mwait = 1'b1;
  logic        busrq_n, busak_n = 1'b1;
  logic [15:0] addr;
  logic [7:0]  dmaster, dslave;
  logic        mreq_n, rdn, wrn, bus_own, busy, done, overrun;

  // wraparound instance
  logic        dma_rdy2 = 1'b0, vblk2 = 1'b0;
  logic        busrq2_n, busak2_n = 1'b1;
  logic [15:0] addr2;
  logic [7:0]  dmaster2, dslave2;
  logic        mreq2_n, rdn2, wrn2, bus_own2, busy2, done2, overrun2;

  // zero-length instance
  logic        dma_rdy3 = 1'b0, vblk3 = 1'b0;
  logic        busrq3_n;
  logic [15:0] addr3;
  logic [7:0]  dmaster3;
  logic        mreq3_n, rdn3, wrn3, bus_own3, busy3, done3, overrun3;

  dkong_sprite_dma dut (
    .i_masterclk(clk), .i_rst(rst), .i_dma_rdy(dma_rdy), .i_vblk(vblk),
    .o_busrq_n(busrq_n), .i_busak_n(busak_n), .o_addr(addr), .o_dmaster(dmaster),
    .i_dslave(dslave), .o_mreq_n(mreq_n), .o_rdn(rdn), .o_wrn(wrn), .i_mwait(mwait),
    .o_bus_own(bus_own), .o_busy(busy), .o_done(done), .o_overrun(overrun));

  dkong_sprite_dma #(.SRC_BASE(16'hFFFE), .DST_BASE(16'h7000), .XFER_LEN(4)) dut2 (
    .i_masterclk(clk), .i_rst(rst), .i_dma_rdy(dma_rdy2), .i_vblk(vblk2),
    .o_busrq_n(busrq2_n), .i_busak_n(busak2_n), .o_addr(addr2), .o_dmaster(dmaster2),
    .i_dslave(dslave2), .o_mreq_n(mreq2_n), .o_rdn(rdn2), .o_wrn(wrn2), .i_mwait(1'b1),
    .o_bus_own(bus_own2), .o_busy(busy2), .o_done(done2), .o_overrun(overrun2));

  dkong_sprite_dma #(.XFER_LEN(0)) dut3 (
    .i_masterclk(clk), .i_rst(rst), .i_dma_rdy(dma_rdy3), .i_vblk(vblk3),
    .o_busrq_n(busrq3_n), .i_busak_n(1'b1), .o_addr(addr3), .o_dmaster(dmaster3),
    .i_dslave(8'h00), .o_mreq_n(mreq3_n), .o_rdn(rdn3), .o_wrn(wrn3), .i_mwait(1'b1),
    .o_bus_own(bus_own3), .o_busy(busy3), .o_done(done3), .o_overrun(overrun3));

  // Bus models: registered read slave, write sink, CPU acknowledging ~3 cycles late
  logic [7:0] src_mem [0:65535];
  logic [7:0] dst_mem [0:65535];
  int ak_cnt = 0;
  always @(posedge clk) begin
    dslave <= src_mem[addr];
    if (!mreq_n && !wrn && mwait) dst_mem[addr] <= dmaster;
    if (busrq_n) begin
      ak_cnt  <= 0;
      busak_n <= 1'b1;
    end else if (ak_cnt < 3) begin
      ak_cnt <= ak_cnt + 1;
    end else begin
      busak_n <= 1'b0;
    end
  end
  always @(posedge clk) begin
    dslave2  <= addr2[7:0];
    busak2_n <= busrq2_n;
  end

  typedef struct packed { logic [15:0] a; logic [7:0] d; } wr_exp_t;
  typedef struct packed { logic pre; logic vb; logic rdy; logic exp_done; } trig_vec_t;

  wr_exp_t     sb_q[$];
  logic [15:0] rdq2[$];

  int checks = 0, failures = 0;
  int wr_idx = 0, last_wr_cyc = 0, rd_idx = 0, rd_run = 0, rd_start = 0;
  int done_cnt = 0, busrq_low = 0, rd2_cnt = 0, done2_cnt = 0;
  int wr_gap [0:4095];
  int rd_len [0:4095];
  logic rdn_prev = 1'b1, rdn2_prev = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sampled on the falling edge, mid-cycle.
  task automatic mon_step();
    wr_exp_t e;
    if (!wrn && !mreq_n && mwait) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected_write actual addr=0x%0h required=no write", addr);
      end else begin
        e = sb_q.pop_front();
        chk("wr_addr", 32'(addr), 32'(e.a));
        chk("wr_data", 32'(dmaster), 32'(e.d));
      end
      if (wr_idx < 4096) wr_gap[wr_idx] = cyc - last_wr_cyc;
      last_wr_cyc = cyc;
      wr_idx++;
    end
    if (!rdn) begin
      if (rdn_prev) rd_start++;
      rd_run++;
    end else if (rd_run > 0) begin
      if (rd_idx < 4096) rd_len[rd_idx] = rd_run;
      rd_idx++;
      rd_run = 0;
    end
    rdn_prev = rdn;
    if (!rdn && !wrn) chk("rd_wr_overlap", 32'(rdn | wrn), 32'd1);
    if (done) done_cnt++;
    if (!busrq_n) busrq_low++;
    if (!rdn2 && rdn2_prev) begin
      rd2_cnt++;
      if (rdq2.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL wrap_unexpected_read actual addr=0x%0h required=no read", addr2);
      end else begin
        chk("wrap_rd_addr", 32'(addr2), 32'(rdq2.pop_front()));
      end
    end
    rdn2_prev = rdn2;
    if (done2) done2_cnt++;
  endtask

  task automatic push_xfer();
    wr_exp_t e;
    for (int i = 0; i < N; i++) begin
      e.a = 16'(16'h7000 + i);
      e.d = src_mem[16'(16'h6900 + i)];
      sb_q.push_back(e);
    end
  endtask

  task automatic wait_done(input int d0, input int budget, input string name);
    int n;
    n = 0;
    while (done_cnt == d0 && n < budget) begin
      tick();
      n++;
    end
    if (done_cnt == d0) begin
      checks++;
      failures++;
      $display("FAIL %s timeout actual=no done required=done within %0d cycles", name, budget);
    end
  endtask

  function automatic int mem_bad();
    int bad;
    bad = 0;
    for (int i = 0; i < N; i++)
      if (dst_mem[16'(16'h7000 + i)] !== 8'((i * 7) & 255)) bad++;
    return bad;
  endfunction

  initial begin
    trig_vec_t tv [6];
    int d0, bw, br, bad, n, b0;

    tv[0] = '{1'b0, 1'b1, 1'b1, 1'b1};  // rising edge, armed
    tv[1] = '{1'b0, 1'b1, 1'b0, 1'b0};  // rising edge, not armed
    tv[2] = '{1'b1, 1'b1, 1'b1, 1'b0};  // level high
    tv[3] = '{1'b1, 1'b0, 1'b1, 1'b0};  // falling edge
    tv[4] = '{1'b0, 1'b0, 1'b1, 1'b0};  // level low
    tv[5] = '{1'b0, 1'b1, 1'b1, 1'b1};  // rising edge again

    for (int i = 0; i < N; i++) src_mem[16'(16'h6900 + i)] = 8'((i * 7) & 255);

    fork
      forever begin
        @(negedge clk);
        mon_step();
      end
    join_none

    // reset values
    repeat (3) tick();
    chk("rst_busrq_n", 32'(busrq_n), 32'd1);
    chk("rst_mreq_n", 32'(mreq_n), 32'd1);
    chk("rst_rdn", 32'(rdn), 32'd1);
    chk("rst_wrn", 32'(wrn), 32'd1);
    chk("rst_addr", 32'(addr), 32'd0);
    chk("rst_dmaster", 32'(dmaster), 32'd0);
    chk("rst_bus_own", 32'(bus_own), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    rst = 1'b0;
    tick();

    // trigger truth table on the zero-length instance
    for (int i = 0; i < 6; i++) begin
      vblk3 = tv[i].pre;
      dma_rdy3 = 1'b0;
      tick();
      tick();
      vblk3 = tv[i].vb;
      dma_rdy3 = tv[i].rdy;
      tick();
      chk($sformatf("trig_vec%0d_done", i), 32'(done3), 32'(tv[i].exp_done));
      tick();
      chk($sformatf("trig_vec%0d_done_width", i), 32'(done3), 32'd0);
      chk($sformatf("trig_vec%0d_busrq_n", i), 32'(busrq3_n), 32'd1);
      chk($sformatf("trig_vec%0d_busy", i), 32'(busy3), 32'd0);
    end
    dma_rdy3 = 1'b0;
    vblk3 = 1'b0;

    // vblk rising while not armed
    d0 = done_cnt;
    b0 = busrq_low;
    vblk = 1'b1;
    repeat (30) tick();
    chk("unarmed_busrq", 32'(busrq_low - b0), 32'd0);
    chk("unarmed_done", 32'(done_cnt - d0), 32'd0);
    vblk = 1'b0;
    repeat (2) tick();

    // full transfer with vblk held for three frames' worth of cycles
    dma_rdy = 1'b1;
    d0 = done_cnt;
    bw = wr_idx;
    br = rd_idx;
    push_xfer();
    vblk = 1'b1;
    repeat (6000) tick();
    chk("xfer1_done_cnt", 32'(done_cnt - d0), 32'd1);
    chk("xfer1_writes", 32'(wr_idx - bw), 32'(N));
    chk("xfer1_sb_left", 32'(sb_q.size()), 32'd0);
    bad = 0;
    for (int i = 1; i < N; i++) if (wr_gap[bw + i] != 5) bad++;
    chk("xfer1_spacing_not5", 32'(bad), 32'd0);
    bad = 0;
    for (int i = 0; i < N; i++) if (rd_len[br + i] != 2) bad++;
    chk("xfer1_rdlen_not2", 32'(bad), 32'd0);
    chk("xfer1_mem_bad", 32'(mem_bad()), 32'd0);
    chk("xfer1_busy", 32'(busy), 32'd0);
    chk("xfer1_busrq_n", 32'(busrq_n), 32'd1);
    chk("xfer1_bus_own", 32'(bus_own), 32'd0);
    vblk = 1'b0;
    repeat (2) tick();

    // wait states on byte 10 read
    d0 = done_cnt;
    bw = wr_idx;
    br = rd_idx;
    b0 = rd_start;
    push_xfer();
    vblk = 1'b1;
    n = 0;
    while (rd_start - b0 < 11 && n < 500) begin
      tick();
      n++;
    end
    chk("wait_reached_byte10", 32'(rd_start - b0 >= 11), 32'd1);
    mwait = 1'b0;
    repeat (4) tick();
    mwait = 1'b1;
    wait_done(d0, 3000, "wait_xfer_done");
    chk("wait_rdlen_byte10", 32'(rd_len[br + 10]), 32'd6);
    chk("wait_rdlen_byte9", 32'(rd_len[br + 9]), 32'd2);
    chk("wait_gap_byte10", 32'(wr_gap[bw + 10]), 32'd9);
    chk("wait_writes", 32'(wr_idx - bw), 32'(N));
    chk("wait_sb_left", 32'(sb_q.size()), 32'd0);
    vblk = 1'b0;
    repeat (2) tick();

    // second vblk edge during a transfer
    chk("ovr_before", 32'(overrun), 32'd0);
    d0 = done_cnt;
    bw = wr_idx;
    push_xfer();
    vblk = 1'b1;
    repeat (100) tick();
    vblk = 1'b0;
    tick();
    vblk = 1'b1;
    tick();
    chk("ovr_set", 32'(overrun), 32'd1);
    wait_done(d0, 3000, "ovr_xfer_done");
    repeat (20) tick();
    chk("ovr_done_cnt", 32'(done_cnt - d0), 32'd1);
    chk("ovr_writes", 32'(wr_idx - bw), 32'(N));
    chk("ovr_sb_left", 32'(sb_q.size()), 32'd0);
    chk("ovr_sticky", 32'(overrun), 32'd1);
    vblk = 1'b0;
    repeat (2) tick();

    // reset at byte 200
    d0 = done_cnt;
    bw = wr_idx;
    push_xfer();
    vblk = 1'b1;
    n = 0;
    while (wr_idx - bw < 200 && n < 2000) begin
      tick();
      n++;
    end
    chk("rst200_reached", 32'(wr_idx - bw >= 200), 32'd1);
    rst = 1'b1;
    vblk = 1'b0;
    tick();
    chk("rst200_busrq_n", 32'(busrq_n), 32'd1);
    chk("rst200_mreq_n", 32'(mreq_n), 32'd1);
    chk("rst200_rdn", 32'(rdn), 32'd1);
    chk("rst200_wrn", 32'(wrn), 32'd1);
    chk("rst200_bus_own", 32'(bus_own), 32'd0);
    chk("rst200_busy", 32'(busy), 32'd0);
    chk("rst200_done", 32'(done), 32'd0);
    chk("rst200_overrun", 32'(overrun), 32'd0);
    rst = 1'b0;
    sb_q.delete();
    repeat (10) tick();
    chk("rst200_no_done", 32'(done_cnt - d0), 32'd0);
    d0 = done_cnt;
    bw = wr_idx;
    push_xfer();
    vblk = 1'b1;
    wait_done(d0, 3000, "post_rst_xfer_done");
    chk("post_rst_writes", 32'(wr_idx - bw), 32'(N));
    chk("post_rst_sb_left", 32'(sb_q.size()), 32'd0);
    chk("post_rst_mem_bad", 32'(mem_bad()), 32'd0);
    vblk = 1'b0;
    repeat (2) tick();

    // source address wraparound
    rdq2.push_back(16'hFFFE);
    rdq2.push_back(16'hFFFF);
    rdq2.push_back(16'h0000);
    rdq2.push_back(16'h0001);
    d0 = done2_cnt;
    dma_rdy2 = 1'b1;
    vblk2 = 1'b1;
    n = 0;
    while (done2_cnt == d0 && n < 500) begin
      tick();
      n++;
    end
    chk("wrap_done_seen", 32'(done2_cnt - d0), 32'd1);
    chk("wrap_reads", 32'(rd2_cnt), 32'd4);
    chk("wrap_q_left", 32'(rdq2.size()), 32'd0);
    chk("wrap_busrq_n", 32'(busrq2_n), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
